cu_cache_arbiter: RTL

Round-robin arbiter that shares one `cu_cache` instance between `NUM_REQUESTERS` engines in a compute unit. It accepts one `CacheRequest` per cycle from the winning requester and forwards it, registered, to the cache request port. It records the winner index in an in-order tag FIFO. Because the cache returns responses in request order, the arbiter uses the popped tags to steer each `CacheResponse` back to the requester that issued it.

---
 rtl/cu_cache_arbiter.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/cu_cache_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cu_cache_arbiter
//  Purpose  : Round-robin arbiter that shares one cu_cache between several
//             compute-unit engines. Requests are granted one per cycle and
//             forwarded through an output register. The winner index of
//             every transfer is kept in an in-order tag FIFO, so each
//             in-order cache response can be steered back to its issuer.
//  Revision : 1.0 - initial release
// ============================================================================
module cu_cache_arbiter #(
    parameter int NUM_REQUESTERS = 4,
    parameter int TAG_DEPTH      = 32,
    parameter int REQ_W          = 32,
    parameter int RESP_W         = 32,
    parameter int IDX_W          = $clog2(NUM_REQUESTERS)
) (
    input  logic                             ap_clk,
    input  logic                             areset,
    // requester side: one valid bit and one payload slice per requester
    input  logic [NUM_REQUESTERS-1:0]        request_in_valid,
    input  logic [NUM_REQUESTERS*REQ_W-1:0]  request_in_payload,
    output logic [NUM_REQUESTERS-1:0]        grant_out,
    // cache request port
    output logic                             request_out_valid,
    output logic [REQ_W-1:0]                 request_out_payload,
    input  logic                             cache_prog_full_in,
    // cache response port
    input  logic                             response_in_valid,
    input  logic [RESP_W-1:0]                response_in_payload,
    output logic [NUM_REQUESTERS-1:0]        response_out_valid,
    output logic [NUM_REQUESTERS*RESP_W-1:0] response_out_payload,
    // status
    output logic [$clog2(TAG_DEPTH+1)-1:0]   outstanding_out,
    output logic                             idle_out,
    output logic                             error_out
);

    localparam int c_CNT_W = $clog2(TAG_DEPTH + 1);
    localparam int c_PTR_W = $clog2(TAG_DEPTH);

    // boundary registers
    logic                     r_prog_full;
    logic                     r_resp_valid;
    logic [RESP_W-1:0]        r_resp_payload;

    // arbitration and forward path
    logic [IDX_W-1:0]         r_ptr;
    logic                     r_req_valid;
    logic [REQ_W-1:0]         r_req_payload;

    // tag FIFO
    logic [IDX_W-1:0]         r_tag_mem [TAG_DEPTH];
    logic [c_PTR_W-1:0]       r_wr_ptr;
    logic [c_PTR_W-1:0]       r_rd_ptr;
    logic [c_CNT_W-1:0]       r_count;

    // response path and status
    logic [NUM_REQUESTERS-1:0] r_resp_out_valid;
    logic [RESP_W-1:0]         r_resp_out_payload;
    logic                      r_idle;
    logic                      r_error;

    logic                     w_found;
    logic [IDX_W-1:0]         w_winner;
    logic                     w_eligible;
    logic                     w_transfer;
    logic                     w_pop;
    logic                     w_orphan;
    logic [IDX_W-1:0]         w_pop_tag;
    logic [REQ_W-1:0]         w_win_payload;
    logic [c_CNT_W-1:0]       w_count_next;

    // Scan requesters starting at the priority pointer; first valid one wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < NUM_REQUESTERS; k++) begin
            int idx;
            idx = int'(r_ptr) + k;
            if (idx >= NUM_REQUESTERS) begin
                idx = idx - NUM_REQUESTERS;
            end
            if (!w_found && request_in_valid[idx]) begin
                w_found  = 1'b1;
                w_winner = IDX_W'(idx);
            end
        end
    end

    // Granting needs cache headroom and a free tag slot.
    assign w_eligible    = ~r_prog_full & (r_count < c_CNT_W'(TAG_DEPTH));
    assign w_transfer    = w_found & w_eligible;
    assign w_win_payload = request_in_payload[int'(w_winner)*REQ_W +: REQ_W];

    // One-hot grant to the winner while eligible.
    always_comb begin
        grant_out = '0;
        if (w_transfer) begin
            grant_out[w_winner] = 1'b1;
        end
    end

    // A registered response pops a tag only if one is held; otherwise it is an orphan.
    assign w_pop     = r_resp_valid & (r_count != '0);
    assign w_orphan  = r_resp_valid & (r_count == '0);
    assign w_pop_tag = r_tag_mem[r_rd_ptr];

    // Occupancy after this cycle's push/pop.
    always_comb begin
        w_count_next = r_count;
        if (w_transfer && !w_pop) begin
            w_count_next = r_count + c_CNT_W'(1);
        end else if (!w_transfer && w_pop) begin
            w_count_next = r_count - c_CNT_W'(1);
        end
    end

    // Register cache-side inputs at the CU boundary.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            r_prog_full  <= 1'b0;
            r_resp_valid <= 1'b0;
        end else begin
            r_prog_full  <= cache_prog_full_in;
            r_resp_valid <= response_in_valid;
        end
    end

    // Response payload needs no reset; its valid qualifies it.
    always_ff @(posedge ap_clk) begin
        r_resp_payload <= response_in_payload;
    end

    // Advance the priority pointer past each winner and flag forwarded requests.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            r_ptr       <= '0;
            r_req_valid <= 1'b0;
        end else begin
            r_req_valid <= w_transfer;
            if (w_transfer) begin
                if (int'(w_winner) == NUM_REQUESTERS - 1) begin
                    r_ptr <= '0;
                end else begin
                    r_ptr <= w_winner + IDX_W'(1);
                end
            end
        end
    end

    // Capture the winning payload for the cache request port.
    always_ff @(posedge ap_clk) begin
        if (w_transfer) begin
            r_req_payload <= w_win_payload;
        end
    end

    // Tag storage: winner index written on every transfer.
    always_ff @(posedge ap_clk) begin
        if (w_transfer) begin
            r_tag_mem[r_wr_ptr] <= w_winner;
        end
    end

    // Tag FIFO pointers and occupancy; pointers wrap naturally at TAG_DEPTH.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_transfer) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= w_count_next;
        end
    end

    // Steer each popped response to the requester named by its tag.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            r_resp_out_valid <= '0;
        end else begin
            r_resp_out_valid <= '0;
            if (w_pop) begin
                r_resp_out_valid[w_pop_tag] <= 1'b1;
            end
        end
    end

    // Steered payload is shared by all ports; the per-port valid qualifies it.
    always_ff @(posedge ap_clk) begin
        if (w_pop) begin
            r_resp_out_payload <= r_resp_payload;
        end
    end

    // Idle once no tags are held and nothing sits in the output register; error is sticky.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            r_idle  <= 1'b1;
            r_error <= 1'b0;
        end else begin
            r_idle  <= (w_count_next == '0) & ~w_transfer;
            r_error <= r_error | w_orphan;
        end
    end

    generate
        for (genvar g = 0; g < NUM_REQUESTERS; g++) begin : g_resp_payload
            assign response_out_payload[g*RESP_W +: RESP_W] = r_resp_out_payload;
        end
    endgenerate

    assign request_out_valid   = r_req_valid;
    assign request_out_payload = r_req_payload;
    assign response_out_valid  = r_resp_out_valid;
    assign outstanding_out     = r_count;
    assign idle_out            = r_idle;
    assign error_out           = r_error;

endmodule
`default_nettype wire
